// File: rtl/radix4_mul_scan_pkg.sv
// rtl/radix4_mul_scan_pkg.sv - shared state encoding and digit width for the radix-4 scanner
package radix4_mul_scan_pkg;

    // Number of multiplier bits consumed per scan step
    localparam int DIGIT_W = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_MULT = 2'd1,
        RUN       = 2'd2,
        DONE      = 2'd3
    } state_t;

endpackage

// File: rtl/radix4_digit_mux.sv
// rtl/radix4_digit_mux.sv - selects 0, B, 2B or 3B by one radix-4 digit, zero-extended
module radix4_digit_mux
    import radix4_mul_scan_pkg::*;
#(
    parameter int WIDTH = 1024
) (
    input  logic [DIGIT_W-1:0] digit,
    input  logic [WIDTH-1:0]   b1,
    input  logic [WIDTH:0]     b2,
    input  logic [WIDTH+3:0]   b3,
    output logic [2*WIDTH-1:0] multiple
);

    // Digit-indexed multiple; digit 0 contributes nothing
    always_comb begin
        multiple = '0;
        case (digit)
            2'd1:    multiple = {{WIDTH{1'b0}}, b1};
            2'd2:    multiple = {{(WIDTH-1){1'b0}}, b2};
            2'd3:    multiple = {{(WIDTH-4){1'b0}}, b3};
            default: multiple = '0;
        endcase
    end

endmodule

// File: rtl/radix4_mul_scan.sv
// rtl/radix4_mul_scan.sv - MSB-first radix-4 scan multiplier fed by precomputed B/2B/3B
module radix4_mul_scan
    import radix4_mul_scan_pkg::*;
#(
    parameter int WIDTH = 1024
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [WIDTH-1:0]     operand_a,
    input  logic                 mult_valid,
    input  logic [WIDTH-1:0]     operand_b1,
    input  logic [WIDTH:0]       operand_b2,
    input  logic [WIDTH+3:0]     operand_b3,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int DIGITS = WIDTH / 2;
    localparam int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     b1_q, b1_d;
    logic [WIDTH:0]       b2_q, b2_d;
    logic [WIDTH+3:0]     b3_q, b3_d;

    logic [DIGIT_W-1:0]   digit;
    logic [2*WIDTH-1:0]   multiple;

    // The current digit is always the top two bits of the shifting multiplier
    assign digit = a_q[WIDTH-1 -: DIGIT_W];

    radix4_digit_mux #(
        .WIDTH (WIDTH)
    ) u_digit_mux (
        .digit    (digit),
        .b1       (b1_q),
        .b2       (b2_q),
        .b3       (b3_q),
        .multiple (multiple)
    );

    // Next-state, datapath and product update; everything holds by default
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        acc_d     = acc_q;
        product_d = product_q;
        cnt_d     = cnt_q;
        b1_d      = b1_q;
        b2_d      = b2_q;
        b3_d      = b3_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = operand_a;
                    acc_d   = '0;
                    state_d = WAIT_MULT;
                end
            end
            WAIT_MULT: begin
                if (mult_valid) begin
                    b1_d    = operand_b1;
                    b2_d    = operand_b2;
                    b3_d    = operand_b3;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = (acc_q << 2) + multiple;
                a_d   = a_q << 2;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    // Product lands on the edge into DONE so it is valid with the done pulse
                    product_d = acc_d;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-high clear
    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q   <= IDLE;
            a_q       <= '0;
            acc_q     <= '0;
            product_q <= '0;
            cnt_q     <= '0;
            b1_q      <= '0;
            b2_q      <= '0;
            b3_q      <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            cnt_q     <= cnt_d;
            b1_q      <= b1_d;
            b2_q      <= b2_d;
            b3_q      <= b3_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign product = product_q;

endmodule

// File: tb/tb_radix4_mul_scan.sv
// tb/tb_radix4_mul_scan.sv - scoreboard bench for radix4_mul_scan against an arithmetic model
module tb_radix4_mul_scan;

    localparam int W      = 1024;
    localparam int DIGITS = W / 2;

    typedef logic [W-1:0]   op_t;
    typedef logic [2*W-1:0] prod_t;

    logic           clk;
    logic           resetn;
    logic           start;
    logic [W-1:0]   operand_a;
    logic           mult_valid;
    logic [W-1:0]   operand_b1;
    logic [W:0]     operand_b2;
    logic [W+3:0]   operand_b3;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    radix4_mul_scan #(.WIDTH(W)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .operand_a  (operand_a),
        .mult_valid (mult_valid),
        .operand_b1 (operand_b1),
        .operand_b2 (operand_b2),
        .operand_b3 (operand_b3),
        .busy       (busy),
        .done       (done),
        .product    (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    prod_t exp_q[$];
    int    exp_cyc_q[$];
    int    n_cmp  = 0;
    int    n_err  = 0;
    int    n_done = 0;

    task automatic cmp_prod(string name, prod_t act, prod_t req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got hi=%h lo=%h, want hi=%h lo=%h", name,
                     act[2*W-1 -: 64], act[63:0], req[2*W-1 -: 64], req[63:0]);
        end
    endtask

    task automatic cmp_int(string name, int act, int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    function automatic op_t rand_op();
        op_t r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    // Reference product from plain full-width integer multiplication
    function automatic prod_t ref_mul(op_t a, op_t b);
        prod_t x;
        prod_t y;
        x = {{W{1'b0}}, a};
        y = {{W{1'b0}}, b};
        return x * y;
    endfunction

    // Monitor: every done pulse pops one expected product and its expected cycle
    always @(negedge clk) begin
        if (done) begin
            n_done++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: done seen at cycle %0d with nothing expected", cyc);
            end else begin
                prod_t e;
                int    c;
                e = exp_q.pop_front();
                c = exp_cyc_q.pop_front();
                cmp_prod("product", product, e);
                cmp_int("done_cycle", cyc, c);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_mult(op_t b);
        mult_valid = 1'b1;
        operand_b1 = b;
        operand_b2 = {b, 1'b0};
        operand_b3 = {4'b0, b} + {3'b0, b, 1'b0};
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < DIGITS + 20 && !seen; i++) begin
            tick();
            if (done) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL done_timeout: no done within %0d cycles", DIGITS + 20);
            exp_q.delete();
            exp_cyc_q.delete();
        end
    endtask

    // delay = cycles from the start cycle to the mult_valid cycle (>= 1)
    task automatic run_op(op_t a, op_t b, int delay, prod_t exp, bit inject, bit start_in_done);
        bit seen;
        tick();
        start     = 1'b1;
        operand_a = a;
        tick();
        start     = 1'b0;
        operand_a = rand_op();
        for (int i = 1; i < delay; i++) begin
            cmp_int("busy_wait", int'(busy), 1);
            tick();
        end
        cmp_int("busy_wait", int'(busy), 1);
        drive_mult(b);
        exp_q.push_back(exp);
        exp_cyc_q.push_back(cyc + DIGITS + 1);
        tick();
        mult_valid = 1'b0;
        if (inject) begin
            repeat (5) tick();
            start     = 1'b1;
            operand_a = rand_op();
            drive_mult(rand_op());
            tick();
            start      = 1'b0;
            mult_valid = 1'b0;
        end
        wait_done(seen);
        if (seen) begin
            if (start_in_done) begin
                start     = 1'b1;
                operand_a = rand_op();
            end
            tick();
            start = 1'b0;
            cmp_int("busy_after_done", int'(busy), 0);
            repeat (3) tick();
            cmp_prod("product_hold", product, exp);
        end
    endtask

    initial begin
        op_t   a;
        op_t   b;
        op_t   ones;
        prod_t one;
        prod_t t;
        bit    seen;
        int    dones_before;

        resetn     = 1'b1;
        start      = 1'b0;
        mult_valid = 1'b0;
        operand_a  = '0;
        operand_b1 = '0;
        operand_b2 = '0;
        operand_b3 = '0;
        ones       = '1;
        one        = 1;
        repeat (3) tick();
        resetn = 1'b0;
        cmp_int("reset_busy", int'(busy), 0);
        cmp_int("reset_done", int'(done), 0);
        cmp_prod("reset_product", product, '0);

        // mult_valid in IDLE must not start anything
        drive_mult(rand_op());
        tick();
        mult_valid = 1'b0;
        tick();
        cmp_int("idle_mult_ignored", int'(busy), 0);

        // Small operands, mult_valid two cycles after start
        a = 3; b = 5;
        run_op(a, b, 2, prod_t'(15), 1'b0, 1'b0);

        // Zero operands either side; start in the done cycle is dropped
        run_op('0, ones, 1, '0, 1'b0, 1'b1);
        run_op(ones, '0, 3, '0, 1'b0, 1'b0);

        // All ones times all ones: 2^(2W) - 2^(W+1) + 1
        t = one << (W + 1);
        t = prod_t'(0) - t + one;
        run_op(ones, ones, 1, t, 1'b0, 1'b0);

        // A=1 with a long wait for the multiples
        a = 1;
        run_op(a, ones, 10, {{W{1'b0}}, ones}, 1'b0, 1'b0);

        // Mid-run start and second mult_valid are ignored
        a = rand_op(); b = rand_op();
        run_op(a, b, 2, ref_mul(a, b), 1'b1, 1'b0);

        // Random operands and random multiple delays
        for (int k = 0; k < 4; k++) begin
            a = rand_op(); b = rand_op();
            run_op(a, b, int'($urandom_range(1, 6)), ref_mul(a, b), 1'b0, 1'b0);
        end

        // Reset at digit 200 aborts without done
        a = rand_op(); b = rand_op();
        tick();
        start     = 1'b1;
        operand_a = a;
        tick();
        start = 1'b0;
        drive_mult(b);
        tick();
        mult_valid = 1'b0;
        repeat (200) tick();
        cmp_int("busy_before_abort", int'(busy), 1);
        resetn = 1'b1;
        tick();
        resetn = 1'b0;
        cmp_int("abort_busy", int'(busy), 0);
        cmp_int("abort_done", int'(done), 0);
        cmp_prod("abort_product", product, '0);
        dones_before = n_done;
        repeat (DIGITS + 10) tick();
        cmp_int("abort_no_done", n_done, dones_before);
        cmp_prod("abort_product_still_zero", product, '0);

        // Fresh operation after the abort
        a = rand_op(); b = rand_op();
        run_op(a, b, 2, ref_mul(a, b), 1'b0, 1'b0);

        seen = (exp_q.size() == 0);
        cmp_int("scoreboard_drained", int'(seen), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1);
    end

endmodule
